zb_fifo_drain_ctrl: RTL and testbench
=====================================

# zb_fifo_drain_ctrl

Readout scheduler for the demodulator's output FIFO (CORDIC → CDR → elastic FIFO chain). It watches the FIFO status flags and decides when to drain the FIFO. It issues single-cycle read strobes, captures the read data and hands each word to a downstream consumer over a valid/ready handshake. It also recovers from FIFO overflow by flushing, and keeps drain and error statistics for the debug register bank.

## Interface
Parameters:
- DATA_W, 8, FIFO word width
- BURST_LEN, 16, maximum words drained per burst (≥1)
- IDLE_TMO, 1024, cycles a non-empty FIFO may sit below almost-full before a drain starts (≥2)

Ports:
- clk  in  1  system clock, 50 MHz
- reset_n  in  1  synchronous, active-low reset
- i_enable  in  1  when low, no new burst starts; a burst in progress completes
- i_fifo_empty  in  1  FIFO empty flag
- i_fifo_almost_full  in  1  FIFO almost-full flag
- i_fifo_full  in  1  FIFO full flag
- i_fifo_read_error  in  1  FIFO read-underflow pulse
- i_fifo_data  in  DATA_W  FIFO read data, valid one cycle after o_fifo_rd_en
- o_fifo_rd_en  out  1  FIFO read strobe, one cycle per word
- o_data  out  DATA_W  word presented to the consumer
- o_valid  out  1  o_data valid
- i_ready  in  1  consumer accepts when o_valid & i_ready
- o_busy  out  1  FSM not in IDLE
- o_overflow  out  1  sticky flag, set when full is seen; cleared by reset only
- o_err_cnt  out  8  saturating count of i_fifo_read_error pulses
- o_word_cnt  out  16  wrapping count of words delivered (handshakes)
- o_drop_cnt  out  16  wrapping count of words discarded during FLUSH

## Operation
- States: IDLE, READ, CAPT, OUT, FLUSH.
- Idle timer:
  - Counts while in IDLE with !i_fifo_empty.
  - Clears when the FIFO is empty or the FSM leaves IDLE.
- Transitions out of IDLE, in this priority order:
  - i_fifo_full → FLUSH, and set o_overflow.
  - Otherwise, i_enable & !empty & (almost_full | timer == IDLE_TMO-1) → READ, and load words_left = BURST_LEN.
- READ: assert o_fifo_rd_en for exactly one cycle → CAPT.
- CAPT:
  - Register i_fifo_data into o_data.
  - Decrement words_left.
  - → OUT.
- OUT:
  - Hold o_valid=1 with o_data stable until i_ready.
  - On handshake, o_word_cnt++.
  - Next state: READ if words_left ≠ 0 & !empty; else FLUSH if full; else IDLE.
- FLUSH:
  - Assert o_fifo_rd_en every cycle while !empty.
  - o_drop_cnt++ per strobe issued.
  - o_valid stays 0.
  - → IDLE on the first cycle empty is seen.
  - i_enable is ignored.
- i_fifo_read_error: o_err_cnt++ (saturates at 255) in any state.
  - If it occurs in CAPT, the captured word is still delivered.
- Full seen while in OUT: the current word is still delivered; only then → FLUSH.
- o_fifo_rd_en is never asserted while i_fifo_empty=1.

## Timing
- Reset values:
  - o_fifo_rd_en=0, o_valid=0, o_data=0, o_busy=0, o_overflow=0.
  - All counters 0; state IDLE.
- A reset mid-burst abandons the held word; no handshake completes.
- Start latency: o_fifo_rd_en rises 1 cycle after the start condition is registered in IDLE.
- o_valid rises 2 cycles after o_fifo_rd_en (READ → CAPT → OUT).
- With i_ready held high: one word every 3 cycles (16.7 Mword/s). This is far above the demod output rate.
- FLUSH throughput: one word per cycle. Exit happens the cycle after the last strobe's empty.
- All outputs are registered. o_busy equals (state ≠ IDLE) registered, i.e. high from the READ or FLUSH cycle onward.

## Structure
- Shared package zb_pkg holds:
  - the typedef drain_state_e {IDLE, READ, CAPT, OUT, FLUSH};
  - the localparam ERR_CNT_MAX = 8'hFF.
- Sub-module zb_sat_counter (parameterised width, saturate/wrap select) is used for o_err_cnt, o_word_cnt and o_drop_cnt.
- The FSM, idle timer and burst counter stay in the top module.

## Test plan
- Almost-full burst:
  - Stimulus: FIFO model preloaded with 20 words 0x01..0x14; almost_full=1; i_ready=1.
  - Response: 16 words 0x01..0x10 delivered at 3-cycle spacing, then IDLE; o_word_cnt=16.
- Idle timeout:
  - Stimulus: 3 words loaded, almost_full=0.
  - Response: the first o_fifo_rd_en comes exactly IDLE_TMO+1 cycles after empty falls; 3 words delivered; FSM returns to IDLE when empty.
- Backpressure:
  - Stimulus: i_ready low for 10 cycles on the 2nd word.
  - Response: o_data holds 0x02 stable and o_valid stays high for those 10 cycles; no o_fifo_rd_en during the stall.
- Overflow flush:
  - Stimulus: assert full with 32 words queued.
  - Response: o_overflow=1; 32 consecutive rd_en strobes; o_drop_cnt=32; o_valid never high.
- Read error and enable:
  - Stimulus: 300 read_error pulses.
  - Response: o_err_cnt=255.
  - Stimulus: i_enable=0 with almost_full=1.
  - Response: no burst starts.
- Reset mid-OUT:
  - Stimulus: reset_n low during OUT.
  - Response: all outputs at their reset values the next cycle; o_overflow cleared.

Source files
------------

// File: rtl/zb_pkg.sv
// Shared types and constants for the demodulator output FIFO drain controller.
package zb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CAPT  = 3'd2,
    OUT   = 3'd3,
    FLUSH = 3'd4
  } drain_state_e;

  localparam int unsigned ERR_CNT_W   = 8;
  localparam logic [7:0]  ERR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/zb_sat_counter.sv
// Event counter with selectable saturate-at-MAX or free-running wrap behaviour.
module zb_sat_counter #(
  parameter int unsigned      WIDTH    = 8,
  parameter bit               SATURATE = 1'b0,
  parameter logic [WIDTH-1:0] MAX      = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_inc && !(SATURATE && (count_q == MAX))) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/zb_fifo_drain_ctrl.sv
// Drain scheduler for the demodulator output FIFO: bursts on almost-full or idle
// timeout, valid/ready delivery, overflow flush, and debug statistics.
module zb_fifo_drain_ctrl
  import zb_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned IDLE_TMO  = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_enable,
  input  logic              i_fifo_empty,
  input  logic              i_fifo_almost_full,
  input  logic              i_fifo_full,
  input  logic              i_fifo_read_error,
  input  logic [DATA_W-1:0] i_fifo_data,
  output logic              o_fifo_rd_en,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_overflow,
  output logic [7:0]        o_err_cnt,
  output logic [15:0]       o_word_cnt,
  output logic [15:0]       o_drop_cnt
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TMR_W   = (IDLE_TMO > 2) ? $clog2(IDLE_TMO) : 1;
  localparam int unsigned BURST_W = $clog2(BURST_LEN + 1);
  localparam logic [TMR_W-1:0]   TMO_LAST   = TMR_W'(IDLE_TMO - 1);
  localparam logic [BURST_W-1:0] BURST_LOAD = BURST_W'(BURST_LEN);

  drain_state_e        state_q, state_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [BURST_W-1:0]  words_left_q, words_left_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                rd_en_q, rd_en_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                overflow_q, overflow_d;

  logic                start_ok;
  logic                handshake;
  logic                rd_strobe;

  // The empty flag trails a read by one cycle, so the last flush strobe is
  // qualified with the live flag to avoid reading past the final word.
  assign rd_strobe = rd_en_q & ~i_fifo_empty;
  assign handshake = valid_q & i_ready;
  assign start_ok  = i_enable & ~i_fifo_empty &
                     (i_fifo_almost_full | (timer_q == TMO_LAST));

  // Next-state, burst bookkeeping and registered-output decode
  always_comb begin
    state_d      = state_q;
    timer_d      = '0;
    words_left_d = words_left_q;
    data_d       = data_q;
    overflow_d   = overflow_q | i_fifo_full;

    case (state_q)
      IDLE: begin
        if (i_fifo_full) begin
          state_d = FLUSH;
        end else if (start_ok) begin
          state_d      = READ;
          words_left_d = BURST_LOAD;
        end else if (!i_fifo_empty) begin
          // Saturate so a disabled controller still starts once re-enabled
          timer_d = (timer_q == TMO_LAST) ? timer_q : timer_q + TMR_W'(1);
        end
      end
      READ: begin
        state_d = CAPT;
      end
      CAPT: begin
        data_d       = i_fifo_data;
        words_left_d = words_left_q - BURST_W'(1);
        state_d      = OUT;
      end
      OUT: begin
        if (handshake) begin
          if ((words_left_q != '0) && !i_fifo_empty) begin
            state_d = READ;
          end else if (i_fifo_full) begin
            state_d = FLUSH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        if (i_fifo_empty) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    rd_en_d = (state_d == READ) | (state_d == FLUSH);
    valid_d = (state_d == OUT);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      words_left_q <= '0;
      data_q       <= '0;
      rd_en_q      <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      words_left_q <= words_left_d;
      data_q       <= data_d;
      rd_en_q      <= rd_en_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
    end
  end

  zb_sat_counter #(
    .WIDTH    (ERR_CNT_W),
    .SATURATE (1'b1),
    .MAX      (ERR_CNT_MAX)
  ) u_err_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_inc   (i_fifo_read_error),
    .o_count (o_err_cnt)
  );

  zb_sat_counter #(
    .WIDTH    (CNT_W),
    .SATURATE (1'b0)
  ) u_word_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_inc   (handshake),
    .o_count (o_word_cnt)
  );

  zb_sat_counter #(
    .WIDTH    (CNT_W),
    .SATURATE (1'b0)
  ) u_drop_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_inc   (rd_strobe & (state_q == FLUSH)),
    .o_count (o_drop_cnt)
  );

  assign o_fifo_rd_en = rd_strobe;
  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_busy       = busy_q;
  assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_zb_fifo_drain_ctrl.sv
// Bench for zb_fifo_drain_ctrl: queue-based FIFO, cycle-level behavioural model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_zb_fifo_drain_ctrl;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BURST_LEN = 16;
  localparam int unsigned IDLE_TMO  = 1024;

  localparam int M_IDLE  = 0;
  localparam int M_BURST = 1;
  localparam int M_FLUSH = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              i_enable;
  logic              i_fifo_empty;
  logic              i_fifo_almost_full;
  logic              i_fifo_full;
  logic              i_fifo_read_error;
  logic [DATA_W-1:0] i_fifo_data;
  logic              o_fifo_rd_en;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              i_ready;
  logic              o_busy;
  logic              o_overflow;
  logic [7:0]        o_err_cnt;
  logic [15:0]       o_word_cnt;
  logic [15:0]       o_drop_cnt;

  zb_fifo_drain_ctrl #(
    .DATA_W    (DATA_W),
    .BURST_LEN (BURST_LEN),
    .IDLE_TMO  (IDLE_TMO)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .i_enable           (i_enable),
    .i_fifo_empty       (i_fifo_empty),
    .i_fifo_almost_full (i_fifo_almost_full),
    .i_fifo_full        (i_fifo_full),
    .i_fifo_read_error  (i_fifo_read_error),
    .i_fifo_data        (i_fifo_data),
    .o_fifo_rd_en       (o_fifo_rd_en),
    .o_data             (o_data),
    .o_valid            (o_valid),
    .i_ready            (i_ready),
    .o_busy             (o_busy),
    .o_overflow         (o_overflow),
    .o_err_cnt          (o_err_cnt),
    .o_word_cnt         (o_word_cnt),
    .o_drop_cnt         (o_drop_cnt)
  );

  always #10 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit chk_on = 1'b0;

  logic [DATA_W-1:0] fq[$];
  logic [DATA_W-1:0] hs_data[$];
  int                hs_cyc[$];
  bit                last_rd;

  // Behavioural model state
  int                m_mode, m_pos, m_left, m_wait, m_err, m_words, m_drops;
  bit                m_ovf;
  logic [DATA_W-1:0] m_data;
  bit                e_rd, e_valid, e_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model: advance on each edge from the inputs of the cycle just ending
  initial begin
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        m_mode = M_IDLE; m_pos = 0; m_left = 0; m_wait = 0;
        m_err = 0; m_words = 0; m_drops = 0; m_ovf = 1'b0; m_data = '0;
      end else begin
        if (i_fifo_full) m_ovf = 1'b1;
        if (i_fifo_read_error && m_err < 255) m_err++;
        case (m_mode)
          M_IDLE: begin
            if (i_fifo_full) begin
              m_mode = M_FLUSH; m_wait = 0;
            end else if (i_enable && !i_fifo_empty &&
                         (i_fifo_almost_full || m_wait >= int'(IDLE_TMO) - 1)) begin
              m_mode = M_BURST; m_pos = 0; m_left = int'(BURST_LEN); m_wait = 0;
            end else begin
              m_wait = i_fifo_empty ? 0 : m_wait + 1;
            end
          end
          M_BURST: begin
            if (m_pos == 0) begin
              m_pos = 1;
            end else if (m_pos == 1) begin
              m_data = i_fifo_data;
              m_pos  = 2;
            end else if (i_ready) begin
              m_words++;
              m_left--;
              if (m_left > 0 && !i_fifo_empty) m_pos = 0;
              else if (i_fifo_full)            m_mode = M_FLUSH;
              else                             m_mode = M_IDLE;
            end
          end
          default: begin
            if (i_fifo_empty) m_mode = M_IDLE;
            else              m_drops++;
          end
        endcase
      end
    end
  end

  // Every-cycle compare plus handshake monitor, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on && reset_n) begin
        e_rd    = ((m_mode == M_BURST && m_pos == 0) || m_mode == M_FLUSH) && !i_fifo_empty;
        e_valid = (m_mode == M_BURST && m_pos == 2);
        e_busy  = (m_mode != M_IDLE);
        chk("rd_en", 32'(o_fifo_rd_en), 32'(e_rd));
        chk("rd_while_empty", 32'(o_fifo_rd_en & i_fifo_empty), 32'd0);
        chk("valid", 32'(o_valid), 32'(e_valid));
        chk("busy", 32'(o_busy), 32'(e_busy));
        chk("data", 32'(o_data), 32'(m_data));
        chk("overflow", 32'(o_overflow), 32'(m_ovf));
        chk("err_cnt", 32'(o_err_cnt), 32'(m_err));
        chk("word_cnt", 32'(o_word_cnt), 32'(16'(m_words)));
        chk("drop_cnt", 32'(o_drop_cnt), 32'(16'(m_drops)));
        if (o_valid && i_ready) begin
          hs_data.push_back(o_data);
          hs_cyc.push_back(cyc);
        end
      end
    end
  end

  // One clock: sample the strobe mid-cycle, then update the FIFO after the edge
  task automatic tick();
    @(negedge clk);
    last_rd = o_fifo_rd_en;
    @(posedge clk);
    #1;
    if (last_rd && fq.size() > 0) i_fifo_data = fq.pop_front();
    i_fifo_empty = (fq.size() == 0);
  endtask

  task automatic push_words(input int first, input int count);
    for (int i = 0; i < count; i++) fq.push_back(DATA_W'(first + i));
    i_fifo_empty = (fq.size() == 0);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    fq.delete();
    i_enable = 1'b1; i_fifo_almost_full = 1'b0; i_fifo_full = 1'b0;
    i_fifo_read_error = 1'b0; i_fifo_data = '0; i_fifo_empty = 1'b1; i_ready = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    hs_data.delete();
    hs_cyc.delete();
    chk_on = 1'b1;
  endtask

  int rd_k, n_rd, first_rd, last_rd_cyc, k;
  bit saw_valid, was_busy;

  initial begin
    reset_n = 1'b0;
    i_enable = 1'b1; i_fifo_almost_full = 1'b0; i_fifo_full = 1'b0;
    i_fifo_read_error = 1'b0; i_fifo_data = '0; i_fifo_empty = 1'b1; i_ready = 1'b1;
    apply_reset();

    // Reset values
    chk("rst_rd_en", 32'(o_fifo_rd_en), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_overflow", 32'(o_overflow), 32'd0);
    chk("rst_counters", 32'(o_err_cnt) + 32'(o_word_cnt) + 32'(o_drop_cnt), 32'd0);

    // Almost-full burst: 20 words queued, one 16-word burst at 3-cycle spacing
    push_words(1, 20);
    i_fifo_almost_full = 1'b1;
    for (k = 0; k < 10 && !last_rd; k++) tick();
    i_fifo_almost_full = 1'b0;
    for (k = 0; k < 200 && hs_data.size() < 16; k++) tick();
    repeat (3) tick();
    chk("af_word_cnt", 32'(o_word_cnt), 32'd16);
    chk("af_model_words", 32'(m_words), 32'd16);
    chk("af_busy_after", 32'(o_busy), 32'd0);
    chk("af_left_in_fifo", 32'(fq.size()), 32'd4);
    for (int i = 0; i < 16 && i < hs_data.size(); i++) begin
      chk("af_word", 32'(hs_data[i]), 32'(i + 1));
      if (i > 0) chk("af_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd3);
    end

    // Idle timeout: 3 words, no almost-full
    apply_reset();
    push_words(8'h31, 3);
    rd_k = -1;
    for (k = 0; k < int'(IDLE_TMO) + 20; k++) begin
      tick();
      if (last_rd) begin
        rd_k = k;
        break;
      end
    end
    // Distance measured from the last cycle the empty flag was high
    chk("tmo_first_rd", 32'(rd_k + 1), 32'(IDLE_TMO + 1));
    for (k = 0; k < 100 && !(hs_data.size() == 3 && !o_busy); k++) tick();
    chk("tmo_words", 32'(o_word_cnt), 32'd3);
    chk("tmo_idle", 32'(o_busy), 32'd0);
    chk("tmo_last_word", 32'(o_data), 32'h33);

    // Backpressure on the second word
    apply_reset();
    push_words(1, 5);
    i_fifo_almost_full = 1'b1;
    for (k = 0; k < 10 && !last_rd; k++) tick();
    i_fifo_almost_full = 1'b0;
    for (k = 0; k < 50 && !(o_valid && o_data == 8'h02); k++) tick();
    i_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_rd_idle", 32'(last_rd), 32'd0);
      chk("bp_valid_held", 32'(o_valid), 32'd1);
      chk("bp_data_held", 32'(o_data), 32'h02);
    end
    i_ready = 1'b1;
    for (k = 0; k < 60 && !(hs_data.size() == 5 && !o_busy); k++) tick();
    chk("bp_words", 32'(o_word_cnt), 32'd5);

    // Overflow flush with 32 words queued
    apply_reset();
    push_words(8'h40, 32);
    i_fifo_full = 1'b1;
    tick();
    i_fifo_full = 1'b0;
    n_rd = 0; first_rd = -1; last_rd_cyc = -1; saw_valid = 1'b0; was_busy = 1'b0;
    for (k = 0; k < 100; k++) begin
      tick();
      if (last_rd) begin
        n_rd++;
        if (first_rd < 0) first_rd = k;
        last_rd_cyc = k;
      end
      if (o_valid) saw_valid = 1'b1;
      if (o_busy) was_busy = 1'b1;
      if (was_busy && !o_busy) break;
    end
    chk("ovf_flag", 32'(o_overflow), 32'd1);
    chk("ovf_strobes", 32'(n_rd), 32'd32);
    chk("ovf_consecutive", 32'(last_rd_cyc - first_rd + 1), 32'd32);
    chk("ovf_drop_cnt", 32'(o_drop_cnt), 32'd32);
    chk("ovf_model_drops", 32'(m_drops), 32'd32);
    chk("ovf_no_valid", 32'(saw_valid), 32'd0);

    // Read errors saturate; disabled controller never starts
    apply_reset();
    i_fifo_read_error = 1'b1;
    repeat (300) tick();
    i_fifo_read_error = 1'b0;
    tick();
    chk("err_saturate", 32'(o_err_cnt), 32'd255);
    i_enable = 1'b0;
    i_fifo_almost_full = 1'b1;
    push_words(1, 4);
    n_rd = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (last_rd) n_rd++;
    end
    chk("en_low_no_rd", 32'(n_rd), 32'd0);
    chk("en_low_idle", 32'(o_busy), 32'd0);
    i_enable = 1'b1;
    repeat (2) tick();
    chk("en_high_starts", 32'(o_busy), 32'd1);

    // Reset while a word is held in OUT
    apply_reset();
    push_words(8'h55, 3);
    i_fifo_almost_full = 1'b1;
    i_ready = 1'b0;
    for (k = 0; k < 20 && !o_valid; k++) tick();
    i_fifo_full = 1'b1;
    tick();
    i_fifo_full = 1'b0;
    tick();
    chk("mid_out_ovf_set", 32'(o_overflow), 32'd1);
    chk("mid_out_holding", 32'(o_valid), 32'd1);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_rd_en", 32'(o_fifo_rd_en), 32'd0);
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_data", 32'(o_data), 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_ovf", 32'(o_overflow), 32'd0);
    chk("mid_rst_words", 32'(o_word_cnt), 32'd0);

    // Randomised traffic against the model
    apply_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0 && fq.size() < 48) push_words(int'($urandom_range(0, 255)), 1);
      i_fifo_almost_full = (fq.size() >= 12);
      i_fifo_full        = (fq.size() >= 40);
      i_ready            = ($urandom_range(0, 3) != 0);
      i_enable           = ($urandom_range(0, 7) != 0);
      i_fifo_read_error  = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
